// File: rtl/free_list.sv
// free_list: physical-register free list for the rename stage.
// Circular buffer of free PR tags with a speculative head (dispatch),
// a retire head (architectural point) and a tail (release point).
// A squash rewinds the speculative head to the retire head, reclaiming
// every tag handed to a non-retired instruction.
// Optional build macro: FREE_LIST_CHECK_EN adds sticky protocol checking
// on fl_error plus simulation $error reports; without it fl_error is 0.
module free_list #(
    parameter int N_WAY   = 2,
    parameter int N_PR    = 64,
    parameter int N_ARCH  = 32,
    parameter int PR_BITS = $clog2(N_PR)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_WAY-1:0]         dis_valid,
    input  logic [N_WAY-1:0]         retire_valid,
    input  logic [N_WAY*PR_BITS-1:0] retire_pr_old,
    input  logic                     squash,
    output logic [N_WAY*PR_BITS-1:0] pr_freelist,
    output logic [PR_BITS:0]         free_count,
    output logic                     fl_stall,
    output logic                     fl_error
);
    // Pointers carry one wrap bit above the entry index so that a full
    // and an empty window are distinguishable by subtraction.
    localparam int PTR_W  = PR_BITS + 1;
    localparam int N_INIT = N_PR - N_ARCH - 1;
    localparam logic [PTR_W-1:0] CAP = PTR_W'(N_INIT);

    logic [PR_BITS-1:0] entry_q [N_PR];
    logic [PR_BITS-1:0] entry_d [N_PR];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] ret_head_q, ret_head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] free_count_q, free_count_d;

    logic [PTR_W-1:0]   dis_rank [N_WAY];
    logic [PTR_W-1:0]   ret_rank [N_WAY];
    logic [PTR_W-1:0]   dis_acc, ret_acc;
    logic [PTR_W-1:0]   n_alloc, n_free;
    logic [N_WAY-1:0]   grant;
    logic [PR_BITS-1:0] rd_idx [N_WAY];
    logic [PR_BITS-1:0] wr_idx [N_WAY];

    // Rank of each slot among the requesting slots below it; the totals give
    // the number of releases this cycle.
    always_comb begin
        dis_acc = '0;
        ret_acc = '0;
        for (int i = 0; i < N_WAY; i++) begin
            dis_rank[i] = dis_acc;
            ret_rank[i] = ret_acc;
            dis_acc     = dis_acc + PTR_W'(dis_valid[i]);
            ret_acc     = ret_acc + PTR_W'(retire_valid[i]);
        end
        n_free = ret_acc;
    end

    // Offer window: requesting slot i reads entry[head + rank_i] as long as
    // the list still holds that many entries; squash suppresses all offers.
    always_comb begin
        pr_freelist = '0;
        n_alloc     = '0;
        for (int i = 0; i < N_WAY; i++) begin
            rd_idx[i] = PR_BITS'(head_q + dis_rank[i]);
            grant[i]  = dis_valid[i] && !squash && (dis_rank[i] < free_count_q);
            pr_freelist[i*PR_BITS +: PR_BITS] = grant[i] ? entry_q[rd_idx[i]] : '0;
            n_alloc   = n_alloc + PTR_W'(grant[i]);
        end
    end

    // Release window: valid retire slots are packed in slot order at tail.
    // Written entries lie outside the offer window, so no bypass is needed.
    always_comb begin
        entry_d = entry_q;
        for (int i = 0; i < N_WAY; i++) begin
            wr_idx[i] = PR_BITS'(tail_q + ret_rank[i]);
            if (retire_valid[i]) begin
                entry_d[wr_idx[i]] = retire_pr_old[i*PR_BITS +: PR_BITS];
            end
        end
    end

    // Pointer and count update; a squash recomputes the count from the
    // retire-to-tail distance since all speculative allocations return.
    always_comb begin
        tail_d     = tail_q + n_free;
        ret_head_d = ret_head_q + n_free;
        if (squash) begin
            head_d       = ret_head_d;
            free_count_d = tail_d - ret_head_d;
        end else begin
            head_d       = head_q + n_alloc;
            free_count_d = free_count_q - n_alloc + n_free;
        end
    end

    // State registers; reset loads PRs N_ARCH+1..N_PR-1 as the free image.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_PR; i++) begin
                entry_q[i] <= (i < N_INIT) ? PR_BITS'(i + N_ARCH + 1) : '0;
            end
            head_q       <= '0;
            ret_head_q   <= '0;
            tail_q       <= CAP;
            free_count_q <= CAP;
        end else begin
            entry_q      <= entry_d;
            head_q       <= head_d;
            ret_head_q   <= ret_head_d;
            tail_q       <= tail_d;
            free_count_q <= free_count_d;
        end
    end

    assign free_count = free_count_q;
    assign fl_stall   = free_count_q < PTR_W'(N_WAY);

`ifdef FREE_LIST_CHECK_EN
    logic             err_zero, err_dup, err_over, err_pass;
    logic             fl_error_q, fl_error_d;
    logic [PTR_W:0]   count_ext;
    logic [PTR_W-1:0] in_flight;

    // Classify this cycle's retire traffic against the release rules.
    always_comb begin
        err_zero = 1'b0;
        err_dup  = 1'b0;
        for (int i = 0; i < N_WAY; i++) begin
            if (retire_valid[i] && (retire_pr_old[i*PR_BITS +: PR_BITS] == '0)) begin
                err_zero = 1'b1;
            end
            for (int j = i + 1; j < N_WAY; j++) begin
                if (retire_valid[i] && retire_valid[j] &&
                    (retire_pr_old[i*PR_BITS +: PR_BITS] == retire_pr_old[j*PR_BITS +: PR_BITS])) begin
                    err_dup = 1'b1;
                end
            end
        end
        // One extra bit so an over-release cannot alias back into range.
        count_ext  = squash ? {1'b0, tail_d - ret_head_d}
                            : {1'b0, free_count_q} - {1'b0, n_alloc} + {1'b0, n_free};
        err_over   = count_ext > {1'b0, CAP};
        in_flight  = head_q - ret_head_q;
        err_pass   = n_free > in_flight;
        fl_error_d = fl_error_q | err_zero | err_dup | err_over | err_pass;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fl_error_q <= 1'b0;
        end else begin
            fl_error_q <= fl_error_d;
        end
    end

    // Report each violation in simulation as it happens.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (err_zero) $error("free_list: retire released tag 0");
            if (err_dup)  $error("free_list: two retire slots released the same tag");
            if (err_over) $error("free_list: release overfills the list");
            if (err_pass) $error("free_list: retire head passed the dispatch head");
        end
    end

    assign fl_error = fl_error_q;
`else
    assign fl_error = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: scenario tasks for free_list with a tag-queue scoreboard.
// The model tracks free tags in offer order, in-flight (allocated, not
// retired) tags and architectural tags; expected offers are queued when
// stimulus is driven and popped when the DUT outputs are sampled.
module tb_free_list;
    logic        clock         = 1'b0;
    logic        reset         = 1'b1;
    logic [1:0]  dis_valid     = '0;
    logic [1:0]  retire_valid  = '0;
    logic [11:0] retire_pr_old = '0;
    logic        squash        = 1'b0;
    logic [11:0] pr_freelist;
    logic [6:0]  free_count;
    logic        fl_stall;
    logic        fl_error;

    int checks = 0;
    int errors = 0;
    int fq[$];
    int infl[$];
    int arch[$];
    int exp_q[$];
    int exp_fc;

    free_list #(.N_WAY(2), .N_PR(64), .N_ARCH(32), .PR_BITS(6)) dut (
        .clock(clock), .reset(reset), .dis_valid(dis_valid),
        .retire_valid(retire_valid), .retire_pr_old(retire_pr_old),
        .squash(squash), .pr_freelist(pr_freelist), .free_count(free_count),
        .fl_stall(fl_stall), .fl_error(fl_error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        dis_valid = '0; retire_valid = '0; retire_pr_old = '0; squash = 1'b0;
    endtask

    task automatic model_reset();
        fq.delete(); infl.delete(); arch.delete(); exp_q.delete();
        for (int t = 33; t < 64; t++) fq.push_back(t);
        for (int t = 1; t < 33; t++) arch.push_back(t);
        exp_fc = 31;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_reset();
    endtask

    // Drive one cycle of stimulus, queue the expected offers and advance
    // the model to its post-edge state.
    task automatic drive(input logic [1:0] dv, input logic [1:0] rv,
                         input int t0, input int t1, input logic sq);
        int r;
        int na;
        dis_valid = dv; retire_valid = rv; squash = sq;
        retire_pr_old = {6'(t1), 6'(t0)};
        r = 0; na = 0;
        for (int i = 0; i < 2; i++) begin
            if (dv[i] && !sq && r < fq.size()) begin
                exp_q.push_back(fq[r]);
                na++;
            end else begin
                exp_q.push_back(0);
            end
            if (dv[i]) r++;
        end
        for (int k = 0; k < na; k++) infl.push_back(fq.pop_front());
        for (int i = 0; i < 2; i++) if (rv[i] && infl.size() > 0) infl.delete(0);
        if (sq) begin
            for (int k = infl.size() - 1; k >= 0; k--) fq.push_front(infl[k]);
            infl.delete();
        end
        if (rv[0]) fq.push_back(t0);
        if (rv[1]) fq.push_back(t1);
        exp_fc = fq.size();
    endtask

    // Retire n in-flight instructions: each frees an architectural tag and
    // its own tag becomes architectural.
    task automatic pick_told(input logic [1:0] rv, output int t0, output int t1);
        int n;
        t0 = 0; t1 = 0; n = 0;
        if (rv[0]) begin t0 = arch.pop_front(); n++; end
        if (rv[1]) begin t1 = arch.pop_front(); n++; end
        for (int k = 0; k < n; k++) arch.push_back(infl[k]);
    endtask

    task automatic test_reset();
        int e;
        do_reset();
        checks++; if (free_count !== 7'd31) begin errors++; $display("FAIL reset free_count: got %0d expected 31", free_count); end
        checks++; if (fl_stall !== 1'b0) begin errors++; $display("FAIL reset fl_stall: got %0b expected 0", fl_stall); end
        checks++; if (fl_error !== 1'b0) begin errors++; $display("FAIL reset fl_error: got %0b expected 0", fl_error); end
        drive(2'b00, 2'b00, 0, 0, 1'b0); #2;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front(); checks++;
            if (pr_freelist[i*6 +: 6] !== 6'(e)) begin errors++; $display("FAIL reset idle offer%0d: got %0d expected %0d", i, pr_freelist[i*6 +: 6], e); end
        end
        tick();
        drive(2'b11, 2'b00, 0, 0, 1'b0); #2;
        checks++; if (pr_freelist !== {6'd34, 6'd33}) begin errors++; $display("FAIL reset first pair: got %h expected 34/33", pr_freelist); end
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front(); checks++;
            if (pr_freelist[i*6 +: 6] !== 6'(e)) begin errors++; $display("FAIL reset offer%0d: got %0d expected %0d", i, pr_freelist[i*6 +: 6], e); end
        end
        tick();
        checks++; if (free_count !== 7'd29) begin errors++; $display("FAIL reset count after pair: got %0d expected 29", free_count); end
    endtask

    task automatic test_partial();
        do_reset();
        drive(2'b10, 2'b00, 0, 0, 1'b0); #2;
        checks++; if (pr_freelist !== {6'd33, 6'd0}) begin errors++; $display("FAIL partial slot1-only: got %h expected 33/0", pr_freelist); end
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        tick();
        drive(2'b11, 2'b00, 0, 0, 1'b0); #2;
        checks++; if (pr_freelist !== {6'd35, 6'd34}) begin errors++; $display("FAIL partial next pair: got %h expected 35/34", pr_freelist); end
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        tick();
        checks++; if (free_count !== 7'd28) begin errors++; $display("FAIL partial free_count: got %0d expected 28", free_count); end
    endtask

    task automatic test_exhaust();
        int e;
        do_reset();
        repeat (15) begin
            drive(2'b11, 2'b00, 0, 0, 1'b0); #2;
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front(); checks++;
                if (pr_freelist[i*6 +: 6] !== 6'(e)) begin errors++; $display("FAIL exhaust drain offer%0d: got %0d expected %0d", i, pr_freelist[i*6 +: 6], e); end
            end
            tick();
        end
        checks++; if (free_count !== 7'd1) begin errors++; $display("FAIL exhaust count one: got %0d expected 1", free_count); end
        checks++; if (fl_stall !== 1'b1) begin errors++; $display("FAIL exhaust stall at one: got %0b expected 1", fl_stall); end
        drive(2'b11, 2'b00, 0, 0, 1'b0); #2;
        checks++; if (pr_freelist !== {6'd0, 6'd63}) begin errors++; $display("FAIL exhaust last tag: got %h expected 0/63", pr_freelist); end
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        tick();
        checks++; if (free_count !== 7'd0) begin errors++; $display("FAIL exhaust empty count: got %0d expected 0", free_count); end
        checks++; if (fl_stall !== 1'b1) begin errors++; $display("FAIL exhaust empty stall: got %0b expected 1", fl_stall); end
        // Release on an empty list: nothing may be offered the same cycle.
        drive(2'b11, 2'b11, 7, 9, 1'b0); #2;
        checks++; if (pr_freelist !== 12'd0) begin errors++; $display("FAIL exhaust no bypass: got %h expected 0", pr_freelist); end
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        tick();
        checks++; if (free_count !== 7'd2) begin errors++; $display("FAIL exhaust refill count: got %0d expected 2", free_count); end
        drive(2'b11, 2'b00, 0, 0, 1'b0); #2;
        checks++; if (pr_freelist !== {6'd9, 6'd7}) begin errors++; $display("FAIL exhaust reclaimed: got %h expected 9/7", pr_freelist); end
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        tick();
        checks++; if (free_count !== 7'(exp_fc)) begin errors++; $display("FAIL exhaust final count: got %0d expected %0d", free_count, exp_fc); end
    endtask

    task automatic test_squash();
        int e;
        do_reset();
        repeat (2) begin
            drive(2'b11, 2'b00, 0, 0, 1'b0); #2;
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front(); checks++;
                if (pr_freelist[i*6 +: 6] !== 6'(e)) begin errors++; $display("FAIL squash alloc offer%0d: got %0d expected %0d", i, pr_freelist[i*6 +: 6], e); end
            end
            tick();
        end
        drive(2'b11, 2'b01, 5, 0, 1'b1); #2;
        checks++; if (pr_freelist !== 12'd0) begin errors++; $display("FAIL squash offers forced: got %h expected 0", pr_freelist); end
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        tick();
        checks++; if (free_count !== 7'd31) begin errors++; $display("FAIL squash count: got %0d expected 31", free_count); end
        drive(2'b11, 2'b00, 0, 0, 1'b0); #2;
        checks++; if (pr_freelist !== {6'd35, 6'd34}) begin errors++; $display("FAIL squash rewind: got %h expected 35/34", pr_freelist); end
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        tick();
        checks++; if (free_count !== 7'(exp_fc)) begin errors++; $display("FAIL squash after count: got %0d expected %0d", free_count, exp_fc); end
    endtask

    task automatic test_wrap();
        int e;
        int t0;
        int t1;
        do_reset();
        drive(2'b11, 2'b00, 0, 0, 1'b0); #2;
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        tick();
        for (int c = 0; c < 40; c++) begin
            pick_told(2'b11, t0, t1);
            drive(2'b11, 2'b11, t0, t1, 1'b0); #2;
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front(); checks++;
                if (pr_freelist[i*6 +: 6] !== 6'(e)) begin errors++; $display("FAIL wrap c%0d offer%0d: got %0d expected %0d", c, i, pr_freelist[i*6 +: 6], e); end
            end
            tick();
            checks++; if (free_count !== 7'd29) begin errors++; $display("FAIL wrap c%0d free_count: got %0d expected 29", c, free_count); end
        end
    endtask

    task automatic test_random();
        int e;
        int t0;
        int t1;
        int nmax;
        logic [1:0] dv;
        logic [1:0] rv;
        logic sq;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            dv   = 2'($urandom_range(0, 3));
            rv   = 2'($urandom_range(0, 3));
            sq   = ($urandom_range(0, 15) == 0);
            nmax = (infl.size() < 2) ? infl.size() : 2;
            if (nmax == 0) rv = 2'b00;
            else if (nmax == 1 && rv == 2'b11) rv = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            pick_told(rv, t0, t1);
            drive(dv, rv, t0, t1, sq); #2;
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front(); checks++;
                if (pr_freelist[i*6 +: 6] !== 6'(e)) begin errors++; $display("FAIL random c%0d offer%0d: got %0d expected %0d", c, i, pr_freelist[i*6 +: 6], e); end
            end
            tick();
            checks++; if (free_count !== 7'(exp_fc)) begin errors++; $display("FAIL random c%0d free_count: got %0d expected %0d", c, free_count, exp_fc); end
            checks++; if (fl_stall !== (exp_fc < 2)) begin errors++; $display("FAIL random c%0d fl_stall: got %0b expected %0b", c, fl_stall, exp_fc < 2); end
        end
`ifndef FREE_LIST_CHECK_EN
        checks++; if (fl_error !== 1'b0) begin errors++; $display("FAIL random fl_error: got %0b expected 0", fl_error); end
`endif
    endtask

    task automatic test_midreset();
        dis_valid = 2'b11; retire_valid = 2'b11; retire_pr_old = {6'd3, 6'd4}; squash = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        model_reset();
        checks++; if (free_count !== 7'd31) begin errors++; $display("FAIL midreset free_count: got %0d expected 31", free_count); end
        drive(2'b11, 2'b00, 0, 0, 1'b0); #2;
        checks++; if (pr_freelist !== {6'd34, 6'd33}) begin errors++; $display("FAIL midreset offers: got %h expected 34/33", pr_freelist); end
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        tick();
        checks++; if (free_count !== 7'd29) begin errors++; $display("FAIL midreset count: got %0d expected 29", free_count); end
    endtask

`ifdef FREE_LIST_CHECK_EN
    task automatic test_error();
        do_reset();
        dis_valid = 2'b01;
        tick();
        idle();
        retire_valid = 2'b01; retire_pr_old = '0;
        tick();
        idle();
        checks++; if (fl_error !== 1'b1) begin errors++; $display("FAIL error set: got %0b expected 1", fl_error); end
        tick(); tick(); tick();
        checks++; if (fl_error !== 1'b1) begin errors++; $display("FAIL error sticky: got %0b expected 1", fl_error); end
        do_reset();
        checks++; if (fl_error !== 1'b0) begin errors++; $display("FAIL error cleared: got %0b expected 0", fl_error); end
    endtask
`endif

    initial begin
        test_reset();
        test_partial();
        test_exhaust();
        test_squash();
        test_wrap();
        test_random();
        test_midreset();
`ifdef FREE_LIST_CHECK_EN
        test_error();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
